// File: rtl/decode_pipe_pkg.sv
// Shared constants, control-field struct and destination-select helper for the decode stage.
package decode_pkg;

  localparam int REG_IDX_W = 3;
  localparam int REG_CNT   = 8;

  localparam logic [1:0] RD_I1   = 2'b00;
  localparam logic [1:0] RD_R    = 2'b01;
  localparam logic [1:0] RD_I2   = 2'b10;
  localparam logic [1:0] RD_LINK = 2'b11;

  localparam logic [1:0] IMM5    = 2'b00;
  localparam logic [1:0] IMM8    = 2'b01;
  localparam logic [1:0] IMM11   = 2'b10;
  localparam logic [1:0] IMM_ILL = 2'b11;

  typedef struct packed {
    logic [REG_IDX_W-1:0] wr_reg;
    logic                 reg_write;
    logic [REG_IDX_W-1:0] rs1;
    logic [REG_IDX_W-1:0] rs2;
  } ctl_t;

  function automatic logic [REG_IDX_W-1:0] dest_sel(
    input logic [1:0]           rd,
    input logic [15:0]          ins,
    input logic [REG_IDX_W-1:0] link
  );
    logic [REG_IDX_W-1:0] r;
    case (rd)
      RD_I1:   r = ins[7:5];
      RD_R:    r = ins[4:2];
      RD_I2:   r = ins[10:8];
      default: r = link;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/decode_pipe_rf_bypass.sv
// 8-entry register file, two combinational reads, one write, optional write-to-read forwarding.
// Latency: reads combinational, writes visible next cycle (same cycle when BYPASS=1).
// Backpressure: none; writes always proceed.
module rf_bypass
  import decode_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter bit BYPASS = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wbEn,
  input  logic [REG_IDX_W-1:0] wbReg,
  input  logic [DATA_W-1:0]    wbData,
  input  logic [REG_IDX_W-1:0] ra1,
  input  logic [REG_IDX_W-1:0] ra2,
  output logic [DATA_W-1:0]    rdat1,
  output logic [DATA_W-1:0]    rdat2
);

  logic [DATA_W-1:0] mem [REG_CNT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_CNT; i++) mem[i] <= '0;
    end else if (wbEn) begin
      mem[wbReg] <= wbData;
    end
  end

  always_comb begin
    rdat1 = mem[ra1];
    rdat2 = mem[ra2];
    if (BYPASS && wbEn && (wbReg == ra1)) rdat1 = wbData;
    if (BYPASS && wbEn && (wbReg == ra2)) rdat2 = wbData;
  end

endmodule

// File: rtl/decode_pipe.sv
// Pipelined decode: register read, immediate extension, destination select behind a valid/ready register.
// Latency: 1 cycle from accept to outValid.
// Backpressure: inReady = outReady | ~outValid; held operands track writeback while stalled.
module decode_pipe
  import decode_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter bit BYPASS   = 1'b1,
  parameter int LINK_REG = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inValid,
  output logic                 inReady,
  input  logic [15:0]          instr,
  input  logic [1:0]           size,
  input  logic                 zeroEx,
  input  logic [1:0]           regDst,
  input  logic                 regWriteIn,
  input  logic                 wbEn,
  input  logic [REG_IDX_W-1:0] wbReg,
  input  logic [DATA_W-1:0]    wbData,
  output logic                 outValid,
  input  logic                 outReady,
  input  logic                 flush,
  output logic [DATA_W-1:0]    rd1,
  output logic [DATA_W-1:0]    rd2,
  output logic [DATA_W-1:0]    imm,
  output logic [REG_IDX_W-1:0] wrReg,
  output logic                 regWriteOut,
  output logic [REG_IDX_W-1:0] rs1Idx,
  output logic [REG_IDX_W-1:0] rs2Idx,
  output logic                 err
);

  localparam logic [REG_IDX_W-1:0] LINK = LINK_REG[REG_IDX_W-1:0];

  logic              accept;
  logic              stall;
  logic              sx;
  logic [DATA_W-1:0] imm_nxt;
  logic [DATA_W-1:0] rf_rd1;
  logic [DATA_W-1:0] rf_rd2;
  ctl_t              ctl_nxt;
  ctl_t              ctl_q;

  assign inReady = outReady | ~outValid;
  assign accept  = inValid & inReady;
  assign stall   = outValid & ~outReady;

  rf_bypass #(
    .DATA_W (DATA_W),
    .BYPASS (BYPASS)
  ) u_rf (
    .clk    (clk),
    .rst    (rst),
    .wbEn   (wbEn),
    .wbReg  (wbReg),
    .wbData (wbData),
    .ra1    (instr[10:8]),
    .ra2    (instr[7:5]),
    .rdat1  (rf_rd1),
    .rdat2  (rf_rd2)
  );

  always_comb begin
    sx      = ~zeroEx;
    imm_nxt = '0;
    case (size)
      IMM5:    imm_nxt = {{(DATA_W-5){sx & instr[4]}}, instr[4:0]};
      IMM8:    imm_nxt = {{(DATA_W-8){sx & instr[7]}}, instr[7:0]};
      IMM11:   imm_nxt = {{(DATA_W-11){sx & instr[10]}}, instr[10:0]};
      default: imm_nxt = '0;
    endcase
  end

  always_comb begin
    ctl_nxt           = '0;
    ctl_nxt.wr_reg    = dest_sel(regDst, instr, LINK);
    ctl_nxt.reg_write = regWriteIn;
    ctl_nxt.rs1       = instr[10:8];
    ctl_nxt.rs2       = instr[7:5];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outValid <= 1'b0;
      rd1      <= '0;
      rd2      <= '0;
      imm      <= '0;
      ctl_q    <= '0;
      err      <= 1'b0;
    end else begin
      if (accept && (size == IMM_ILL)) err <= 1'b1;

      // Flush wins over a colliding accept; the incoming instruction is dropped.
      if (flush) begin
        outValid <= 1'b0;
      end else if (accept) begin
        outValid <= 1'b1;
        rd1      <= rf_rd1;
        rd2      <= rf_rd2;
        imm      <= imm_nxt;
        ctl_q    <= ctl_nxt;
      end else if (outValid && outReady) begin
        outValid <= 1'b0;
      end

      // Keep stalled operands coherent with writeback, independent of BYPASS.
      if (stall && wbEn && (wbReg == ctl_q.rs1)) rd1 <= wbData;
      if (stall && wbEn && (wbReg == ctl_q.rs2)) rd2 <= wbData;
    end
  end

  assign wrReg       = ctl_q.wr_reg;
  assign regWriteOut = ctl_q.reg_write;
  assign rs1Idx      = ctl_q.rs1;
  assign rs2Idx      = ctl_q.rs2;

endmodule
